pivota_order_executor: RTL and testbench
========================================

Name: pivota_order_executor

Overview:
- Consumer side of the Pivota strategy order stream: accepts (order code, quantity) entries produced by compiled strategies, buffers them in a FIFO, and issues them one at a time to an exchange/broker port over a req/ack handshake.
- Tracks net signed position, filled-order count and rejected-order count for the strategy runtime.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- QTY_W, 4, quantity width; matches the strategy quantity field.
- POS_W, 16, signed position width.
- POS_LIMIT, 100, absolute position limit; used only with POSITION_LIMIT_EN.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  order entry offered.
- in_ready  output  1  FIFO can accept; equals !full.
- in_code  input  4  1=BUY, 2=SELL, any other value is invalid.
- in_qty  input  QTY_W  order quantity.
- out_req  output  1  order presented to the exchange.
- out_ack  input  1  exchange accepts/fills the presented order.
- out_side  output  1  1=BUY, 0=SELL; valid while out_req.
- out_qty  output  QTY_W  quantity; valid while out_req.
- position  output  POS_W  signed net position.
- filled_count  output  16  orders acknowledged.
- reject_count  output  16  orders dropped (invalid code, zero qty, limit).
- busy  output  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. FIFO emptied, FSM set to IDLE.
- Push rule: an entry is written when in_valid && in_ready.
  - in_ready depends only on full, never on same-cycle pop.
  - No combinational path from in_valid to in_ready.
- FIFO: read/write pointers with an extra wrap bit.
  - full = DEPTH stored entries.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop while not full keeps occupancy unchanged.
- FSM has two states: IDLE and REQ.
- IDLE:
  - If the FIFO is non-empty, pop the head into the holding register (code, qty).
  - Check the entry. It is invalid if the code is not 1 or 2, or qty == 0.
  - Invalid entry: reject_count increments and the FSM stays IDLE. One pop per cycle.
  - Valid entry: go to REQ, with out_req=1 registered the next cycle.
  - out_ack is ignored in IDLE.
- REQ:
  - out_req, out_side and out_qty are held stable until out_ack is sampled high.
  - On ack, the next cycle: out_req=0, position += qty (BUY) or -= qty (SELL), filled_count += 1, FSM returns to IDLE.
  - Back-to-back orders therefore have a minimum 1-cycle out_req low gap.
- Latency: entry pushed at edge N; popped at edge N+1; out_req high after edge N+2 (2 cycles, FIFO previously empty).
- Capacity with out_ack held low: DEPTH+1 entries are accepted (one in the holding register, DEPTH in the FIFO) before in_ready falls.
- Arithmetic:
  - qty is zero-extended to POS_W.
  - position saturates at the signed max/min; it never wraps.
  - filled_count and reject_count saturate at 0xFFFF.
- Reset mid-operation:
  - A reset during REQ drops the held order without counting it.
  - out_req=0 after the reset edge; FIFO contents are discarded.

Optional Feature:
- Macro name: POSITION_LIMIT_EN.
- Defined:
  - The IDLE check also rejects a valid order if |position ± qty| > POS_LIMIT.
  - The check uses the position value at pop time, computed at POS_W+1 bits.
  - A rejected order is counted in reject_count and never issued.
- Undefined: no limit check and POS_LIMIT is unused. Only the saturation rule applies.

Test Plan:
- Push BUY 5, BUY 1, BUY 1 with out_ack asserted the cycle after each out_req -> three handshakes with out_qty 5,1,1 and out_side=1; final position=7, filled_count=3, reject_count=0.
- Push codes 3, then 0, then SELL qty 0 -> no out_req; reject_count=3; busy drops once the FIFO drains.
- Hold out_ack=0 and push continuously -> exactly DEPTH+1 (17) accepts, then in_ready=0. Release out_ack -> all 17 issued in order (check FIFO pointer wrap on a second pass) and in_ready returns to 1 after the first pop.
- Push SELL 3, then pulse rst while out_req=1 -> out_req=0, position=0, counts=0, busy=0, in_ready=1 after the reset edge. A new BUY 2 then completes normally.
- With POSITION_LIMIT_EN and POS_LIMIT=10: push BUY 8, then BUY 5, then SELL 4 -> only BUY 8 and SELL 4 are issued; position=4, reject_count=1.
- Push BUY 15 repeatedly with POS_W=8 and the macro undefined -> position saturates at 127 and does not wrap.

Source files
------------

// File: rtl/pivota_order_executor.sv
// Pivota order executor: buffers strategy orders in a FIFO and issues them one at a time over req/ack.
// Optional macro POSITION_LIMIT_EN adds an absolute position limit check against POS_LIMIT.
module pivota_order_executor #(
  parameter int DEPTH     = 16,
  parameter int QTY_W     = 4,
  parameter int POS_W     = 16,
  parameter int POS_LIMIT = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_code,
  input  logic [QTY_W-1:0]        in_qty,
  output logic                    out_req,
  input  logic                    out_ack,
  output logic                    out_side,
  output logic [QTY_W-1:0]        out_qty,
  output logic signed [POS_W-1:0] position,
  output logic [15:0]             filled_count,
  output logic [15:0]             reject_count,
  output logic                    busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || QTY_W >= POS_W || POS_LIMIT < 0) begin : g_param_check
    $error("pivota_order_executor: illegal parameter combination");
  end

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [3:0]       mem_code [DEPTH];
  logic [QTY_W-1:0] mem_qty  [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;
  logic             hold_valid;
  logic [3:0]       hold_code;
  logic [QTY_W-1:0] hold_qty;
  logic             hold_ok;

  logic signed [POS_W:0]   pos_ext, qty_ext, pos_sum;
  logic signed [POS_W-1:0] pos_next;

  // The extra pointer bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = !empty || hold_valid || (state != IDLE);

  // A held entry that fails its check frees the holding register the same cycle.
  assign pop = (state == IDLE) && !empty && (!hold_valid || !hold_ok);

  always_comb begin
    pos_ext = {position[POS_W-1], position};
    qty_ext = {{(POS_W+1-QTY_W){1'b0}}, hold_qty};
    pos_sum = (hold_code == 4'd1) ? (pos_ext + qty_ext) : (pos_ext - qty_ext);
    if (pos_sum[POS_W] != pos_sum[POS_W-1]) begin
      pos_next = pos_sum[POS_W] ? POS_MIN : POS_MAX;
    end else begin
      pos_next = pos_sum[POS_W-1:0];
    end
  end

`ifdef POSITION_LIMIT_EN
  localparam logic signed [POS_W:0] LIM = (POS_W+1)'(POS_LIMIT);
  always_comb begin
    hold_ok = ((hold_code == 4'd1) || (hold_code == 4'd2)) && (hold_qty != '0)
              && (pos_sum <= LIM) && (pos_sum >= -LIM);
  end
`else
  always_comb begin
    hold_ok = ((hold_code == 4'd1) || (hold_code == 4'd2)) && (hold_qty != '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_ptr[AW-1:0]] <= in_code;
      mem_qty[wr_ptr[AW-1:0]]  <= in_qty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      state        <= IDLE;
      hold_valid   <= 1'b0;
      hold_code    <= '0;
      hold_qty     <= '0;
      out_req      <= 1'b0;
      out_side     <= 1'b0;
      out_qty      <= '0;
      position     <= '0;
      filled_count <= '0;
      reject_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        hold_code  <= mem_code[rd_ptr[AW-1:0]];
        hold_qty   <= mem_qty[rd_ptr[AW-1:0]];
        hold_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_valid) begin
            if (hold_ok) begin
              state    <= REQ;
              out_req  <= 1'b1;
              out_side <= (hold_code == 4'd1);
              out_qty  <= hold_qty;
            end else begin
              if (reject_count != 16'hFFFF) begin
                reject_count <= reject_count + 16'd1;
              end
              if (!pop) begin
                hold_valid <= 1'b0;
              end
            end
          end
        end
        REQ: begin
          if (out_ack) begin
            state      <= IDLE;
            out_req    <= 1'b0;
            hold_valid <= 1'b0;
            position   <= pos_next;
            if (filled_count != 16'hFFFF) begin
              filled_count <= filled_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pivota_order_executor.sv
// Self-checking bench for pivota_order_executor: directed scenarios plus random traffic against a queue-based model.
// A second instance with POS_W=8 exercises position saturation.
module tb_pivota_order_executor;

  localparam int DEPTH = 16;
  localparam int QTY_W = 4;
`ifdef POSITION_LIMIT_EN
  localparam int LIMIT = 10;
`else
  localparam int LIMIT = 100;
`endif

  logic clk, rst, in_valid, out_ack;
  logic [3:0] in_code;
  logic [QTY_W-1:0] in_qty;
  logic in_ready, out_req, out_side, busy;
  logic [QTY_W-1:0] out_qty;
  logic signed [15:0] position;
  logic [15:0] filled_count, reject_count;
  logic in_ready8, out_req8, out_side8, busy8;
  logic [QTY_W-1:0] out_qty8;
  logic signed [7:0] position8;
  logic [15:0] filled8, reject8;

  pivota_order_executor #(.DEPTH(DEPTH), .QTY_W(QTY_W), .POS_W(16), .POS_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_qty(in_qty), .out_req(out_req), .out_ack(out_ack), .out_side(out_side),
    .out_qty(out_qty), .position(position), .filled_count(filled_count),
    .reject_count(reject_count), .busy(busy));

  pivota_order_executor #(.DEPTH(DEPTH), .QTY_W(QTY_W), .POS_W(8), .POS_LIMIT(LIMIT)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_code(in_code),
    .in_qty(in_qty), .out_req(out_req8), .out_ack(out_ack), .out_side(out_side8),
    .out_qty(out_qty8), .position(position8), .filled_count(filled8),
    .reject_count(reject8), .busy(busy8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic side;
    int   qty;
  } order_t;

  order_t iq[$];
  int errors = 0;
  int checks = 0;
  int proj_pos, pos16, pos8, filled_m, rej_m;
  int ack_mode;
  logic prev_req, prev_hs, last_push;

  function automatic int sat(input int v, input int w);
    int mx, mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Order outcomes are decided at push time: each order is checked against the
  // position left behind by all earlier issued orders.
  task automatic model_push(input int code, input int qty);
    int nxt;
    logic ok;
    ok = (code == 1 || code == 2) && qty != 0;
    nxt = proj_pos + ((code == 1) ? qty : -qty);
`ifdef POSITION_LIMIT_EN
    if (ok && (nxt > LIMIT || nxt < -LIMIT)) ok = 1'b0;
`endif
    if (!ok) begin
      rej_m++;
    end else begin
      proj_pos = sat(nxt, 16);
      iq.push_back('{side: (code == 1), qty: qty});
    end
  endtask

  task automatic step();
    order_t o;
    int d;
    logic hs;
    check("position", int'(position), pos16);
    check("position8", int'(position8), pos8);
    check("filled_count", int'(filled_count), filled_m);
    check("filled_count8", int'(filled8), filled_m);
    checks++;
    if (int'(reject_count) > rej_m) begin
      errors++;
      $display("[TB] FAIL reject_bound: got %0d, at most %0d", reject_count, rej_m);
    end
    if (iq.size() != 0) check("busy_inflight", int'(busy), 1);
    if (prev_hs) check("req_gap", int'(out_req), 0);
    else if (prev_req) check("req_hold", int'(out_req), 1);
    if (out_req) begin
      if (iq.size() == 0) begin
        check("req_unexpected", int'(out_req), 0);
      end else begin
        check("out_side", int'(out_side), int'(iq[0].side));
        check("out_qty", int'(out_qty), iq[0].qty);
      end
    end
    case (ack_mode)
      0:       out_ack = 1'b0;
      1:       out_ack = 1'b1;
      default: out_ack = 1'($urandom_range(0, 1));
    endcase
    hs = out_req && out_ack;
    last_push = in_valid && in_ready;
    if (hs && iq.size() != 0) begin
      o = iq.pop_front();
      d = o.side ? o.qty : -o.qty;
      pos16 = sat(pos16 + d, 16);
      pos8  = sat(pos8 + d, 8);
      if (filled_m < 65535) filled_m++;
    end
    if (last_push) model_push(int'(in_code), int'(in_qty));
    prev_req = out_req;
    prev_hs  = hs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int code, input int qty);
    logic done;
    done = 1'b0;
    in_valid = 1'b1;
    in_code  = 4'(code);
    in_qty   = QTY_W'(qty);
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      done = last_push;
    end
    in_valid = 1'b0;
    check("push_accepted", int'(done), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(!busy && !out_req && iq.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", int'(n < budget), 1);
    check("reject_count", int'(reject_count), rej_m);
    check("reject_count8", int'(reject8), rej_m);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    iq.delete();
    proj_pos = 0; pos16 = 0; pos8 = 0; filled_m = 0; rej_m = 0;
    prev_req = 1'b0; prev_hs = 1'b0;
    check("rst_out_req", int'(out_req), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_position", int'(position), 0);
    check("rst_filled", int'(filled_count), 0);
    check("rst_reject", int'(reject_count), 0);
    check("rst_out_side", int'(out_side), 0);
    check("rst_out_qty", int'(out_qty), 0);
  endtask

  // Fills the buffer with ack held low, alternating BUY/SELL pairs so any limit stays clear.
  task automatic fill_burst(output int acc);
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_code = (acc % 2 == 0) ? 4'd1 : 4'd2;
      in_qty  = QTY_W'((acc / 2) % 7 + 1);
      step();
      if (last_push) acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    check(name, act, exp);
  endtask

  initial begin
    int acc;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_qty = '0; out_ack = 1'b0;
    ack_mode = 0; prev_req = 1'b0; prev_hs = 1'b0; last_push = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Three BUY orders handshaken back to back.
    ack_mode = 1;
    applyStimulus(1, 5);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    wait_idle(100);
    checkOutput("t1_position", int'(position), 7);
    checkOutput("t1_filled", int'(filled_count), 3);
    checkOutput("t1_reject", int'(reject_count), 0);

    // Invalid entries are dropped without a request.
    applyStimulus(3, 4);
    applyStimulus(0, 7);
    applyStimulus(2, 0);
    wait_idle(100);
    checkOutput("t2_reject", int'(reject_count), 3);
    checkOutput("t2_filled", int'(filled_count), 3);

    // Capacity with ack held low, then release; a second pass wraps the pointers.
    do_reset();
    ack_mode = 0;
    fill_burst(acc);
    checkOutput("cap1_accepts", acc, DEPTH + 1);
    checkOutput("cap1_ready_low", int'(in_ready), 0);
    ack_mode = 1;
    step();
    checkOutput("cap1_ready_after_ack", int'(in_ready), 0);
    step();
    checkOutput("cap1_ready_after_pop", int'(in_ready), 1);
    wait_idle(200);
    checkOutput("cap1_position", int'(position), 2);
    checkOutput("cap1_filled", int'(filled_count), 17);
    ack_mode = 0;
    fill_burst(acc);
    checkOutput("cap2_accepts", acc, DEPTH + 1);
    ack_mode = 2;
    wait_idle(400);
    checkOutput("cap2_position", int'(position), 4);
    checkOutput("cap2_filled", int'(filled_count), 34);

    // Reset while an order is being presented, then a fresh order with its latency pinned.
    ack_mode = 0;
    applyStimulus(2, 3);
    n = 0;
    while (!out_req && n < 10) begin
      step();
      n++;
    end
    checkOutput("t4_req_seen", int'(out_req), 1);
    do_reset();
    applyStimulus(1, 2);
    checkOutput("lat_edge0", int'(out_req), 0);
    step();
    checkOutput("lat_edge1", int'(out_req), 0);
    step();
    checkOutput("lat_edge2", int'(out_req), 1);
    ack_mode = 1;
    wait_idle(50);
    checkOutput("t4_position", int'(position), 2);
    checkOutput("t4_filled", int'(filled_count), 1);

`ifdef POSITION_LIMIT_EN
    do_reset();
    ack_mode = 1;
    applyStimulus(1, 8);
    applyStimulus(1, 5);
    applyStimulus(2, 4);
    wait_idle(100);
    checkOutput("lim_position", int'(position), 4);
    checkOutput("lim_reject", int'(reject_count), 1);
    checkOutput("lim_filled", int'(filled_count), 2);
`else
    do_reset();
    ack_mode = 1;
    for (int i = 0; i < 10; i++) applyStimulus(1, 15);
    wait_idle(200);
    checkOutput("sat_position8", int'(position8), 127);
    checkOutput("sat_position16", int'(position), 150);
`endif

    // Random traffic with random acknowledgements.
    do_reset();
    ack_mode = 2;
    for (int i = 0; i < 800; i++) begin
      int sel;
      in_valid = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      if (sel < 2) in_code = 4'd1;
      else if (sel < 4) in_code = 4'd2;
      else in_code = 4'($urandom_range(0, 15));
      in_qty = QTY_W'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0;
    wait_idle(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
